// File: rtl/clock_time_chain_if.sv
// clock_time_chain_if: control, load and time/pulse signals between setup logic and the time counter.
interface clock_time_chain_if;
  logic       clear;
  logic       load;
  logic [1:0] load_sel;
  logic [7:0] load_data;
  logic       run;
  logic       up_down;
  logic [7:0] sec;
  logic [7:0] min;
  logic [7:0] hr;
  logic       tick;
  logic       day_wrap;
  logic       done;
  modport master (
    output clear, load, load_sel, load_data, run, up_down,
    input  sec, min, hr, tick, day_wrap, done
  );
  modport slave (
    input  clear, load, load_sel, load_data, run, up_down,
    output sec, min, hr, tick, day_wrap, done
  );
endinterface

// File: rtl/clock_time_chain.sv
// clock_time_chain: prescaled hh:mm:ss up/down counter with load clamp, per-step tick and day-wrap/expiry pulses.
module clock_time_chain #(
  parameter int CLK_DIV = 50000000,
  parameter int SEC_MOD = 60,
  parameter int MIN_MOD = 60,
  parameter int HR_MOD  = 24
) (
  input logic              clock,
  input logic              reset,
  clock_time_chain_if.slave bus
);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] P_MAX = PW'(CLK_DIV - 1);
  localparam logic [7:0] S_MAX = 8'(SEC_MOD - 1);
  localparam logic [7:0] M_MAX = 8'(MIN_MOD - 1);
  localparam logic [7:0] H_MAX = 8'(HR_MOD - 1);
  logic [PW-1:0] r_pre;
  logic [7:0]    r_sec, r_min, r_hr;
  logic          r_tick, r_day_wrap, r_done;
  logic          w_term, w_zero, w_s_end, w_m_end, w_h_end;
  logic [7:0]    w_sec, w_min, w_hr, w_lim, w_ld;
  assign w_term  = bus.run && r_pre == P_MAX;
  assign w_zero  = r_sec == 8'd0 && r_min == 8'd0 && r_hr == 8'd0;
  assign w_s_end = bus.up_down ? r_sec == S_MAX : r_sec == 8'd0;
  assign w_m_end = bus.up_down ? r_min == M_MAX : r_min == 8'd0;
  assign w_h_end = r_hr == H_MAX;
  // Down-count saturates at 00:00:00; otherwise borrows ripple sec -> min -> hr.
  always_comb begin
    w_sec = r_sec;
    w_min = r_min;
    w_hr  = r_hr;
    if (bus.up_down) begin
      w_sec = w_s_end ? 8'd0 : r_sec + 8'd1;
      w_min = w_s_end ? (w_m_end ? 8'd0 : r_min + 8'd1) : r_min;
      w_hr  = (w_s_end && w_m_end) ? (w_h_end ? 8'd0 : r_hr + 8'd1) : r_hr;
    end else if (!w_zero) begin
      w_sec = w_s_end ? S_MAX : r_sec - 8'd1;
      w_min = w_s_end ? (w_m_end ? M_MAX : r_min - 8'd1) : r_min;
      w_hr  = (w_s_end && w_m_end) ? r_hr - 8'd1 : r_hr;
    end
  end
  assign w_lim = bus.load_sel == 2'd0 ? S_MAX : bus.load_sel == 2'd1 ? M_MAX : H_MAX;
  assign w_ld  = bus.load_data > w_lim ? w_lim : bus.load_data;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pre      <= '0;
      r_sec      <= '0;
      r_min      <= '0;
      r_hr       <= '0;
      r_tick     <= 1'b0;
      r_day_wrap <= 1'b0;
      r_done     <= 1'b0;
    end else if (bus.clear) begin
      r_pre      <= '0;
      r_sec      <= '0;
      r_min      <= '0;
      r_hr       <= '0;
      r_tick     <= 1'b0;
      r_day_wrap <= 1'b0;
      r_done     <= 1'b0;
    end else if (bus.load) begin
      r_pre      <= '0;
      r_tick     <= 1'b0;
      r_day_wrap <= 1'b0;
      r_done     <= 1'b0;
      if (bus.load_sel == 2'd0) r_sec <= w_ld;
      if (bus.load_sel == 2'd1) r_min <= w_ld;
      if (bus.load_sel == 2'd2) r_hr  <= w_ld;
    end else begin
      r_tick     <= w_term;
      r_day_wrap <= w_term && bus.up_down && w_s_end && w_m_end && w_h_end;
      r_done     <= w_term && !bus.up_down && r_hr == 8'd0 && r_min == 8'd0 && r_sec == 8'd1;
      if (bus.run) r_pre <= w_term ? '0 : r_pre + 1'b1;
      if (w_term) begin
        r_sec <= w_sec;
        r_min <= w_min;
        r_hr  <= w_hr;
      end
    end
  end
  assign bus.sec      = r_sec;
  assign bus.min      = r_min;
  assign bus.hr       = r_hr;
  assign bus.tick     = r_tick;
  assign bus.day_wrap = r_day_wrap;
  assign bus.done     = r_done;
endmodule

// File: doc/clock_time_chain.md
# clock_time_chain

Parametrised hours/minutes/seconds time counter driven by the system clock. It is the successor to the single-field counter. It combines a programmable prescaler and three cascaded modulo fields (seconds, minutes, hours) in one block. The block supports up-counting (clock/stopwatch) and down-counting (timer) with field load and clear. It sits between the button/setup logic and the display encoder, and produces per-second and day-wrap/expiry pulses for the alarm and buzzer logic.

## Interface
- CLK_DIV, 50000000: clock cycles per 1-second tick; must be ≥ 2.
- SEC_MOD, 60: seconds modulus.
- MIN_MOD, 60: minutes modulus.
- HR_MOD, 24: hours modulus; must be ≤ 256.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- clear  in  1  synchronous clear of the prescaler and all fields.
- load  in  1  one-cycle strobe that writes load_data into the field selected by load_sel.
- load_sel  in  2  field select: 00 = seconds, 01 = minutes, 10 = hours, 11 = no field.
- load_data  in  8  binary value to load.
- run  in  1  enables the prescaler and counting.
- up_down  in  1  count direction: 1 = up, 0 = down.
- sec  out  8  seconds, binary, range 0..SEC_MOD-1.
- min  out  8  minutes, binary, range 0..MIN_MOD-1.
- hr  out  8  hours, binary, range 0..HR_MOD-1.
- tick  out  1  one-cycle pulse marking each field update.
- day_wrap  out  1  one-cycle pulse when an up-count wraps from max to 00:00:00.
- done  out  1  one-cycle pulse when a down-count reaches 00:00:00.

## Operation
- Priority, highest first: reset > clear > load > counting.
- Reset and clear:
  - prescaler, sec, min and hr go to 0;
  - tick, day_wrap and done go to 0.
- Load:
  - the selected field takes load_data;
  - if load_data ≥ the field's modulus, the field takes modulus-1 (clamp);
  - the prescaler is set to 0, so the next tick comes a full CLK_DIV cycles later;
  - tick, day_wrap and done are 0 in the load cycle;
  - load_sel = 11 resets only the prescaler.
- Prescaler:
  - counts 0..CLK_DIV-1 while run = 1 and holds its value while run = 0;
  - the terminal cycle is any cycle with run = 1 and prescaler = CLK_DIV-1;
  - in the terminal cycle the prescaler returns to 0 and a field step occurs.
- Up step (up_down = 1 sampled in the terminal cycle):
  - sec increments;
  - when sec wraps SEC_MOD-1 → 0, min increments;
  - when min wraps MIN_MOD-1 → 0, hr increments;
  - when hr wraps HR_MOD-1 → 0, all fields become 0 and day_wrap pulses.
- Down step (up_down = 0 sampled in the terminal cycle):
  - sec decrements, with borrow from min and then hr (0 → modulus-1);
  - a step that makes the value 00:00:00 (from 00:00:01) pulses done;
  - a step at 00:00:00 leaves the fields unchanged, with no done and no wrap to max; tick still pulses.
- Changing up_down mid-period has no effect until the next terminal cycle.
- Fields are never outside their ranges, because loads clamp.

## Timing
- All outputs are registered, and their reset value is 0.
- tick, day_wrap and done are asserted in the cycle immediately after the terminal cycle.
  - This is the same cycle in which the new sec/min/hr values appear.
  - Each stays high for exactly one clock.
- Steady run period: tick every CLK_DIV cycles; the first tick comes CLK_DIV cycles after run rises from a zero prescaler.
- A load or clear in a terminal cycle cancels that step: no tick, and the load/clear result is applied.
- Deasserting run freezes the prescaler. On re-enable, counting resumes mid-period, so no period is lost or duplicated.
- An async reset asserted mid-period clears everything immediately. After reset deasserts, counting starts from prescaler 0.

## Test plan
- Run up from reset with CLK_DIV = 4: tick on cycles 4, 8, 12…; sec reads 1, 2, 3 at those ticks; day_wrap and done stay 0.
- Load hr = 23, min = 59, sec = 59, then run up with CLK_DIV = 4:
  - after 4 cycles, fields read 00:00:00;
  - tick and day_wrap pulse together for one cycle.
- Load 00:01:00, then count down: the next tick gives 00:00:59. After 59 more ticks the value is 00:00:00 with done pulsed once. Further ticks keep 00:00:00 with done = 0.
- Load sec with 75 and hr with 30: fields clamp to sec = 59 and hr = 23. Assert load and clear in the same cycle: all fields read 0.
- Drop run at prescaler = 2 for 10 cycles, then restore it: the next tick comes 2 cycles after re-enable. Assert reset mid-count: all outputs read 0 asynchronously.
